bcd_display_seq: RTL

Sequential, parametrised binary-to-seven-segment display driver. It accepts a WIDTH-bit value in unsigned or two's-complement form, converts its magnitude to BCD with an iterative shift-add-3 engine (one bit per clock), and drives DIGITS registered active-low digit patterns plus a sign digit. It adds a load/busy/done handshake, overflow indication and optional leading-zero blanking. It sits between the processor's output register and the board's seven-segment displays.

---
 rtl/bcd_display_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/bcd_display_seq.sv
// bcd_display_seq
//
// Sequential binary to seven-segment display driver. A load captures a
// WIDTH-bit value (unsigned or two's complement). The magnitude is converted
// to BCD by a shift-add-3 (double dabble) engine, one bit per clock. The
// result is then registered as active-low seven-segment patterns.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   value       binary input, sampled on an accepted load
//   signed_mode 1 = value is two's complement, sampled with value
//   load        start request, accepted only while busy = 0
//   busy        high while a conversion is in progress (state decode)
//   done        one-cycle pulse when new patterns appear on the outputs
//   ovf         last result did not fit in DIGITS digits
//   seg_sign    sign digit pattern (dash for negative, blank otherwise)
//   seg_digits  DIGITS patterns, digit 0 (units) in bits [7:0]
//
// Handshake: load is a request that is taken in the cycle it is high while
// busy = 0. A load while busy = 1 is dropped, not queued. done marks the one
// cycle in which fresh outputs are first visible, and busy is already low in
// that cycle, so a load there starts the next conversion immediately.

module bcd_display_seq #(
    parameter int WIDTH    = 12,
    parameter int DIGITS   = 4,
    parameter int BLANK_LZ = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      value,
    input  logic                  signed_mode,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [7:0]            seg_sign,
    output logic [DIGITS*8-1:0]   seg_digits
);

    // ceil(WIDTH/3) BCD digits always hold 2^WIDTH - 1
    localparam int NB   = (WIDTH + 2) / 3;
    localparam int CW   = $clog2(WIDTH + 1);
    localparam int MAXD = (NB > DIGITS) ? NB : DIGITS;

    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  neg_q, neg_d;
    logic [WIDTH-1:0]      mag_q, mag_d;
    logic [4*NB-1:0]       bcd_q, bcd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic [7:0]            seg_sign_q, seg_sign_d;
    logic [DIGITS*8-1:0]   seg_digits_q, seg_digits_d;

    logic [4*NB-1:0]       bcd_adj;
    logic [4*MAXD-1:0]     bcd_ext;
    logic                  ovf_calc;
    logic                  seen_nz;
    logic [3:0]            dig_val;
    logic [DIGITS*8-1:0]   digits_calc;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = 8'hC0;
            4'd1:    c = 8'hF9;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'hB0;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h92;
            4'd6:    c = 8'h82;
            4'd7:    c = 8'hF8;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h90;
            default: c = SEG_BLANK;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d      = state_q;
        neg_d        = neg_q;
        mag_d        = mag_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        ovf_d        = ovf_q;
        seg_sign_d   = seg_sign_q;
        seg_digits_d = seg_digits_q;

        // add-3 correction so that the following shift carries into the next digit
        bcd_adj = bcd_q;
        for (int i = 0; i < NB; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        // zero-extended copy so that digit indices past NB read as zero
        bcd_ext = '0;
        bcd_ext[4*NB-1:0] = bcd_q;

        ovf_calc = 1'b0;
        for (int i = 0; i < MAXD; i++) begin
            if (i >= DIGITS && bcd_ext[4*i +: 4] != 4'd0) begin
                ovf_calc = 1'b1;
            end
        end

        // walk from the most significant digit down; a digit is a leading
        // zero until the first nonzero digit has been seen
        seen_nz     = 1'b0;
        dig_val     = 4'd0;
        digits_calc = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            dig_val = bcd_ext[4*k +: 4];
            if (dig_val != 4'd0) begin
                seen_nz = 1'b1;
            end
            if (ovf_calc) begin
                digits_calc[8*k +: 8] = SEG_DASH;
            end else if (BLANK_LZ != 0 && k != 0 && !seen_nz) begin
                digits_calc[8*k +: 8] = SEG_BLANK;
            end else begin
                digits_calc[8*k +: 8] = seg_code(dig_val);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    neg_d   = signed_mode & value[WIDTH-1];
                    // two's complement negate wraps, so the most negative
                    // value maps to 2^(WIDTH-1) as an unsigned magnitude
                    mag_d   = neg_d ? (~value + WIDTH'(1)) : value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                ovf_d        = ovf_calc;
                seg_sign_d   = neg_q ? SEG_DASH : SEG_BLANK;
                seg_digits_d = digits_calc;
                done_d       = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            neg_q        <= 1'b0;
            mag_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            seg_sign_q   <= SEG_BLANK;
            seg_digits_q <= {DIGITS{SEG_BLANK}};
        end else begin
            state_q      <= state_d;
            neg_q        <= neg_d;
            mag_q        <= mag_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
            seg_sign_q   <= seg_sign_d;
            seg_digits_q <= seg_digits_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign ovf        = ovf_q;
    assign seg_sign   = seg_sign_q;
    assign seg_digits = seg_digits_q;

endmodule
